// File: rtl/a23_copro_pkg.sv
// Shared CP15 op codes, register numbers and
// configuration sequencer state encoding.
package a23_copro_pkg;

  localparam logic [1:0] COPRO_OP_NONE = 2'd0;
  localparam logic [1:0] COPRO_OP_MRC  = 2'd1;
  localparam logic [1:0] COPRO_OP_MCR  = 2'd2;

  localparam logic [3:0] CRN_ID         = 4'd0;
  localparam logic [3:0] CRN_FLUSH      = 4'd1;
  localparam logic [3:0] CRN_CTRL       = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE  = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE = 4'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT,
    S_OFF,
    S_FL,
    S_WA,
    S_WU,
    S_WD,
    S_RD,
    S_CHK,
    S_WC,
    S_DONE
  } cfg_state_e;

endpackage

// File: rtl/a23_copro_cfg_seq.sv
// CP15 access arbiter and atomic cache
// reconfiguration sequencer for Amber 23.
module a23_copro_cfg_seq #(
  parameter int P_VERIFY = 1,
  parameter int P_FLUSH  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_stall,
  input  logic [1:0]  i_core_copro_operation,
  input  logic [3:0]  i_core_copro_crn,
  input  logic [31:0] i_core_copro_write_data,
  input  logic        i_cfg_start,
  input  logic [2:0]  i_cfg_cache_control,
  input  logic [31:0] i_cfg_cacheable,
  input  logic [31:0] i_cfg_updateable,
  input  logic [31:0] i_cfg_disruptive,
  input  logic [31:0] i_copro_read_data,
  output logic [1:0]  o_copro_operation,
  output logic [3:0]  o_copro_crn,
  output logic [31:0] o_copro_write_data,
  output logic        o_core_hold,
  output logic        o_cfg_busy,
  output logic        o_cfg_done,
  output logic        o_cfg_error
);

  import a23_copro_pkg::*;

  cfg_state_e  state;
  cfg_state_e  state_nxt;
  logic [2:0]  snap_ctrl;
  logic [31:0] snap_ca;
  logic [31:0] snap_up;
  logic [31:0] snap_di;
  logic        err_q;
  logic        start_ok;
  logic        adv;
  logic        core_owns;
  logic [1:0]  seq_op;
  logic [3:0]  seq_crn;
  logic [31:0] seq_wd;

  assign start_ok = i_cfg_start && (state == S_IDLE);
  assign adv      = !i_fetch_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      snap_ctrl <= '0;
      snap_ca   <= '0;
      snap_up   <= '0;
      snap_di   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        snap_ctrl <= i_cfg_cache_control;
        snap_ca   <= i_cfg_cacheable;
        snap_up   <= i_cfg_updateable;
        snap_di   <= i_cfg_disruptive;
      end
      // CP15 registers its read data, so CHK sees the RD result
      if (start_ok)
        err_q <= 1'b0;
      else if (state == S_CHK && adv
               && i_copro_read_data != snap_ca)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    seq_op    = COPRO_OP_NONE;
    seq_crn   = CRN_ID;
    seq_wd    = '0;
    unique case (state)
      S_IDLE: begin
        if (i_cfg_start) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_copro_operation == COPRO_OP_NONE && adv)
          state_nxt = S_OFF;
      end
      S_OFF: begin
        seq_op  = COPRO_OP_MCR;
        seq_crn = CRN_CTRL;
        seq_wd  = {29'd0, snap_ctrl[2:1], 1'b0};
        if (adv) state_nxt = (P_FLUSH != 0) ? S_FL : S_WA;
      end
      S_FL: begin
        seq_op  = COPRO_OP_MCR;
        seq_crn = CRN_FLUSH;
        if (adv) state_nxt = S_WA;
      end
      S_WA: begin
        seq_op  = COPRO_OP_MCR;
        seq_crn = CRN_CACHEABLE;
        seq_wd  = snap_ca;
        if (adv) state_nxt = S_WU;
      end
      S_WU: begin
        seq_op  = COPRO_OP_MCR;
        seq_crn = CRN_UPDATEABLE;
        seq_wd  = snap_up;
        if (adv) state_nxt = S_WD;
      end
      S_WD: begin
        seq_op  = COPRO_OP_MCR;
        seq_crn = CRN_DISRUPTIVE;
        seq_wd  = snap_di;
        if (adv) state_nxt = (P_VERIFY != 0) ? S_RD : S_WC;
      end
      S_RD: begin
        seq_op  = COPRO_OP_MRC;
        seq_crn = CRN_CACHEABLE;
        if (adv) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (adv) state_nxt = S_WC;
      end
      S_WC: begin
        seq_op  = COPRO_OP_MCR;
        seq_crn = CRN_CTRL;
        seq_wd  = {29'd0, snap_ctrl};
        if (adv) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign core_owns = (state == S_IDLE) || (state == S_WAIT);

  assign o_copro_operation  = core_owns ? i_core_copro_operation
                                        : seq_op;
  assign o_copro_crn        = core_owns ? i_core_copro_crn
                                        : seq_crn;
  assign o_copro_write_data = core_owns ? i_core_copro_write_data
                                        : seq_wd;

  assign o_core_hold = (state != S_IDLE);
  assign o_cfg_busy  = (state != S_IDLE);
  assign o_cfg_done  = (state == S_DONE);
  assign o_cfg_error = err_q;

endmodule

// File: tb/tb_a23_copro_cfg_seq.sv
// Directed bench for the CP15 configuration
// sequencer, default and reduced parameter sets.
module tb_a23_copro_cfg_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  core_op;
  logic [3:0]  core_crn;
  logic [31:0] core_wd;
  logic        cfg_start;
  logic [2:0]  cfg_ctrl;
  logic [31:0] cfg_ca;
  logic [31:0] cfg_up;
  logic [31:0] cfg_di;
  logic [31:0] rdata;
  logic        bad_rd;

  logic [1:0]  op_a, op_b;
  logic [3:0]  crn_a, crn_b;
  logic [31:0] wd_a, wd_b;
  logic        hold_a, hold_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic        err_a, err_b;

  logic [31:0] regs [16];
  logic [37:0] log_a [$];
  logic [37:0] log_b [$];

  int n_cmp = 0;
  int n_err = 0;
  int na, nb;

  always #5 clk = ~clk;

  a23_copro_cfg_seq dut_a (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_fetch_stall           (stall),
    .i_core_copro_operation  (core_op),
    .i_core_copro_crn        (core_crn),
    .i_core_copro_write_data (core_wd),
    .i_cfg_start             (cfg_start),
    .i_cfg_cache_control     (cfg_ctrl),
    .i_cfg_cacheable         (cfg_ca),
    .i_cfg_updateable        (cfg_up),
    .i_cfg_disruptive        (cfg_di),
    .i_copro_read_data       (rdata),
    .o_copro_operation       (op_a),
    .o_copro_crn             (crn_a),
    .o_copro_write_data      (wd_a),
    .o_core_hold             (hold_a),
    .o_cfg_busy              (busy_a),
    .o_cfg_done              (done_a),
    .o_cfg_error             (err_a)
  );

  a23_copro_cfg_seq #(.P_VERIFY(0), .P_FLUSH(0)) dut_b (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_fetch_stall           (stall),
    .i_core_copro_operation  (core_op),
    .i_core_copro_crn        (core_crn),
    .i_core_copro_write_data (core_wd),
    .i_cfg_start             (cfg_start),
    .i_cfg_cache_control     (cfg_ctrl),
    .i_cfg_cacheable         (cfg_ca),
    .i_cfg_updateable        (cfg_up),
    .i_cfg_disruptive        (cfg_di),
    .i_copro_read_data       (rdata),
    .o_copro_operation       (op_b),
    .o_copro_crn             (crn_b),
    .o_copro_write_data      (wd_b),
    .o_core_hold             (hold_b),
    .o_cfg_busy              (busy_b),
    .o_cfg_done              (done_b),
    .o_cfg_error             (err_b)
  );

  // CP15 model behind dut_a, plus op logs of both instances
  always @(posedge clk) begin
    if (!stall && op_a != 2'd0) begin
      log_a.push_back({op_a, crn_a,
                       (op_a == 2'd2) ? wd_a : 32'd0});
      if (op_a == 2'd2)
        regs[crn_a] <= wd_a;
      else
        rdata <= bad_rd ? 32'hDEAD_BEEF : regs[crn_a];
    end
    if (!stall && op_b != 2'd0)
      log_b.push_back({op_b, crn_b,
                       (op_b == 2'd2) ? wd_b : 32'd0});
  end

  task automatic chk(input string tag,
                     input logic [39:0] obs,
                     input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [2:0] ctl,
                          input logic [31:0] ca,
                          input logic [31:0] up,
                          input logic [31:0] di);
    cfg_ctrl  = ctl;
    cfg_ca    = ca;
    cfg_up    = up;
    cfg_di    = di;
    cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int c0,
                           output int da,
                           output int db);
    int c;
    c  = c0;
    da = -1;
    db = -1;
    while (da < 0 && c < c0 + 40) begin
      if (done_b && db < 0) db = c;
      if (done_a) da = c;
      else begin
        step(1);
        c++;
      end
    end
  endtask

  task automatic chk_logs(input logic [2:0] ctl,
                          input logic [31:0] ca,
                          input logic [31:0] up,
                          input logic [31:0] di);
    logic [37:0] ex [7];
    int k;
    ex[0] = {2'd2, 4'd2, 29'd0, ctl[2:1], 1'b0};
    ex[1] = {2'd2, 4'd1, 32'd0};
    ex[2] = {2'd2, 4'd3, ca};
    ex[3] = {2'd2, 4'd4, up};
    ex[4] = {2'd2, 4'd5, di};
    ex[5] = {2'd1, 4'd3, 32'd0};
    ex[6] = {2'd2, 4'd2, 29'd0, ctl};
    chk("log_a_len", 40'(log_a.size()), 40'd7);
    for (int i = 0; i < 7; i++)
      if (i < log_a.size())
        chk($sformatf("log_a[%0d]", i),
            40'(log_a[i]), 40'(ex[i]));
    chk("log_b_len", 40'(log_b.size()), 40'd5);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 1 || i == 5) continue;
      if (k < log_b.size())
        chk($sformatf("log_b[%0d]", k),
            40'(log_b[k]), 40'(ex[i]));
      k++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    rdata     = '0;
    bad_rd    = 1'b0;
    rst_n     = 1'b0;
    stall     = 1'b0;
    core_op   = '0;
    core_crn  = '0;
    core_wd   = '0;
    cfg_start = 1'b0;
    cfg_ctrl  = '0;
    cfg_ca    = '0;
    cfg_up    = '0;
    cfg_di    = '0;
    #3;
    chk("rst_hold", 40'(hold_a), 40'd0);
    chk("rst_busy", 40'(busy_a), 40'd0);
    chk("rst_done", 40'(done_a), 40'd0);
    chk("rst_err", 40'(err_a), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // basic sequence
    log_a.delete();
    log_b.delete();
    do_start(3'b001, 32'h3, 32'h1, 32'h0);
    chk("basic_busy", 40'(busy_a), 40'd1);
    chk("basic_hold", 40'(hold_a), 40'd1);
    wait_done(0, na, nb);
    chk("basic_lat_a", 40'(na), 40'd9);
    chk("basic_lat_b", 40'(nb), 40'd6);
    chk("basic_err", 40'(err_a), 40'd0);
    chk_logs(3'b001, 32'h3, 32'h1, 32'h0);
    step(1);
    chk("after_busy", 40'(busy_a), 40'd0);
    chk("after_hold", 40'(hold_a), 40'd0);
    chk("after_done", 40'(done_a), 40'd0);
    core_op  = 2'd1;
    core_crn = 4'd5;
    core_wd  = 32'h1234;
    #1;
    chk("pass_op", 40'(op_a), 40'd1);
    chk("pass_crn", 40'(crn_a), 40'd5);
    chk("pass_wd", 40'(wd_a), 40'h1234);
    core_op  = '0;
    core_crn = '0;
    core_wd  = '0;
    #1;

    // stall held for three edges in WU
    log_a.delete();
    log_b.delete();
    do_start(3'b001, 32'h3, 32'h1, 32'h0);
    step(4);
    chk("wu_crn", 40'(crn_a), 40'd4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_op", 40'(op_a), 40'd2);
      chk("stall_crn", 40'(crn_a), 40'd4);
      chk("stall_wd", 40'(wd_a), 40'h1);
    end
    stall = 1'b0;
    wait_done(7, na, nb);
    chk("stall_lat_a", 40'(na), 40'd12);
    chk("stall_lat_b", 40'(nb), 40'd9);
    chk_logs(3'b001, 32'h3, 32'h1, 32'h0);
    step(1);

    // core MCR in flight at start
    core_op  = 2'd2;
    core_crn = 4'd3;
    core_wd  = 32'h55;
    do_start(3'b001, 32'h3, 32'h1, 32'h0);
    chk("wait_op", 40'(op_a), 40'd2);
    chk("wait_crn", 40'(crn_a), 40'd3);
    chk("wait_wd", 40'(wd_a), 40'h55);
    chk("wait_hold", 40'(hold_a), 40'd1);
    step(2);
    chk("wait2_crn", 40'(crn_a), 40'd3);
    core_op  = '0;
    core_crn = '0;
    core_wd  = '0;
    #1;
    chk("wait_op0", 40'(op_a), 40'd0);
    step(1);
    chk("off_op", 40'(op_a), 40'd2);
    chk("off_crn", 40'(crn_a), 40'd2);
    core_op  = 2'd1;
    core_crn = 4'd7;
    #1;
    chk("held_op", 40'(op_a), 40'd2);
    chk("held_crn", 40'(crn_a), 40'd2);
    core_op  = '0;
    core_crn = '0;
    wait_done(3, na, nb);
    chk("flight_lat", 40'(na), 40'd11);
    step(1);

    // readback mismatch, then cleared by next start
    bad_rd = 1'b1;
    do_start(3'b001, 32'h3, 32'h1, 32'h0);
    wait_done(0, na, nb);
    chk("mm_lat", 40'(na), 40'd9);
    chk("mm_err", 40'(err_a), 40'd1);
    chk("mm_err_b", 40'(err_b), 40'd0);
    step(1);
    chk("mm_sticky", 40'(err_a), 40'd1);
    bad_rd = 1'b0;
    do_start(3'b001, 32'h3, 32'h1, 32'h0);
    chk("mm_clear", 40'(err_a), 40'd0);
    wait_done(0, na, nb);
    chk("mm_ok_err", 40'(err_a), 40'd0);
    step(1);

    // async reset while in WA
    do_start(3'b001, 32'h3, 32'h1, 32'h0);
    step(3);
    chk("wa_crn", 40'(crn_a), 40'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_hold", 40'(hold_a), 40'd0);
    chk("mrst_busy", 40'(busy_a), 40'd0);
    chk("mrst_busy_b", 40'(busy_b), 40'd0);
    chk("mrst_op", 40'(op_a), 40'd0);
    chk("mrst_crn", 40'(crn_a), 40'd0);
    chk("mrst_wd", 40'(wd_a), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    core_op  = 2'd2;
    core_crn = 4'd9;
    core_wd  = 32'hCAFE;
    #1;
    chk("rpass_op", 40'(op_a), 40'd2);
    chk("rpass_crn", 40'(crn_a), 40'd9);
    chk("rpass_wd", 40'(wd_a), 40'hCAFE);
    core_op  = '0;
    core_crn = '0;
    core_wd  = '0;
    #1;
    log_a.delete();
    log_b.delete();
    do_start(3'b110, 32'hA5, 32'h0F, 32'hF0);
    wait_done(0, na, nb);
    chk("rerun_lat_a", 40'(na), 40'd9);
    chk("rerun_lat_b", 40'(nb), 40'd6);
    chk("rerun_err", 40'(err_a), 40'd0);
    chk_logs(3'b110, 32'hA5, 32'h0F, 32'hF0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
